// File: rtl/wb_commit_stage_pkg.sv
// rtl/wb_commit_stage_pkg.sv - exception bit layout, ecode constants and cause encoder for wb_commit_stage
package wb_commit_stage_pkg;

  localparam int EXCEP_W = 17;

  localparam int EX_INT  = 0;
  localparam int EX_PIL  = 1;
  localparam int EX_PIS  = 2;
  localparam int EX_PIF  = 3;
  localparam int EX_PME  = 4;
  localparam int EX_PPI  = 5;
  localparam int EX_ADEF = 6;
  localparam int EX_ADEM = 7;
  localparam int EX_ALE  = 8;
  localparam int EX_SYS  = 9;
  localparam int EX_BRK  = 10;
  localparam int EX_INE  = 11;
  localparam int EX_IPE  = 12;
  localparam int EX_FPD  = 13;
  localparam int EX_FPE  = 14;
  localparam int EX_TLBR = 15;
  localparam int EX_ERTN = 16;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_FPD  = 6'h0f;
  localparam logic [5:0] ECODE_FPE  = 6'h12;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  localparam logic [8:0] ESUB_ADEM = 9'd1;

  typedef struct packed {
    logic [5:0] ecode;
    logic [8:0] esubcode;
  } ecode_t;

  function automatic logic [5:0] ecode_of(input int bit_idx);
    case (bit_idx)
      EX_INT:  ecode_of = ECODE_INT;
      EX_PIL:  ecode_of = ECODE_PIL;
      EX_PIS:  ecode_of = ECODE_PIS;
      EX_PIF:  ecode_of = ECODE_PIF;
      EX_PME:  ecode_of = ECODE_PME;
      EX_PPI:  ecode_of = ECODE_PPI;
      EX_ADEF: ecode_of = ECODE_ADE;
      EX_ADEM: ecode_of = ECODE_ADE;
      EX_ALE:  ecode_of = ECODE_ALE;
      EX_SYS:  ecode_of = ECODE_SYS;
      EX_BRK:  ecode_of = ECODE_BRK;
      EX_INE:  ecode_of = ECODE_INE;
      EX_IPE:  ecode_of = ECODE_IPE;
      EX_FPD:  ecode_of = ECODE_FPD;
      EX_FPE:  ecode_of = ECODE_FPE;
      EX_TLBR: ecode_of = ECODE_TLBR;
      default: ecode_of = ECODE_INT;
    endcase
  endfunction

  // Bit 0 has the highest priority; the unused slot 12 carries the privilege fault.
  function automatic ecode_t encode_excep(input logic [15:0] causes_in, input logic ipe);
    logic [15:0] causes;
    causes = causes_in;
    causes[EX_IPE] = ipe;
    encode_excep = '0;
    for (int b = 15; b >= 0; b--) begin
      if (causes[b]) begin
        encode_excep.ecode    = ecode_of(b);
        encode_excep.esubcode = (b == EX_ADEM) ? ESUB_ADEM : 9'd0;
      end
    end
  endfunction

endpackage

// File: rtl/wb_excep_sel.sv
// rtl/wb_excep_sel.sv - oldest-fault lane arbiter, commit mask and ecode/BadV encoder
module wb_excep_sel
  import wb_commit_stage_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic [LANES-1:0]         valid,
  input  logic [LANES*EXCEP_W-1:0] excep_type,
  input  logic [LANES-1:0]         is_kernel,
  input  logic [1:0]               cpu_level,
  input  logic [LANES*PC_W-1:0]    pc,
  input  logic [LANES*DATA_W-1:0]  mem_addr,
  output logic [LANES-1:0]         commit,
  output logic                     excep_en,
  output logic                     ertn_en,
  output logic [5:0]               ecode,
  output logic [8:0]               esubcode,
  output logic [PC_W-1:0]          excep_pc,
  output logic                     badv_we,
  output logic [PC_W-1:0]          badv
);

  logic [LANES-1:0]   ipe;
  logic               found;
  logic [EXCEP_W-1:0] win_type;
  logic               win_ipe;
  logic [PC_W-1:0]    win_pc;
  logic [DATA_W-1:0]  win_addr;
  logic               ertn_only;
  ecode_t             enc;

  assign ipe = {LANES{cpu_level == 2'd3}} & is_kernel;

  // Lanes ahead of the first faulting lane commit; the rest are squashed.
  always_comb begin
    found    = 1'b0;
    commit   = '0;
    win_type = '0;
    win_ipe  = 1'b0;
    win_pc   = '0;
    win_addr = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!found) begin
        if (valid[k] && (ipe[k] || |excep_type[k*EXCEP_W +: EXCEP_W])) begin
          found    = 1'b1;
          win_type = excep_type[k*EXCEP_W +: EXCEP_W];
          win_ipe  = ipe[k];
          win_pc   = pc[k*PC_W +: PC_W];
          win_addr = mem_addr[k*DATA_W +: DATA_W];
        end else begin
          commit[k] = valid[k];
        end
      end
    end
  end

  assign ertn_only = win_type[EX_ERTN] && !(|win_type[15:0]) && !win_ipe;
  assign excep_en  = found && !ertn_only;
  assign ertn_en   = found && ertn_only;
  assign enc       = encode_excep(win_type[15:0], win_ipe);
  assign ecode     = excep_en ? enc.ecode : 6'd0;
  assign esubcode  = excep_en ? enc.esubcode : 9'd0;
  assign excep_pc  = excep_en ? win_pc : '0;
  assign badv_we   = excep_en && (win_type[EX_ADEF] || win_type[EX_ALE]);
  assign badv      = !badv_we ? '0 : (win_type[EX_ADEF] ? win_pc : PC_W'(win_addr));

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - LANES-wide writeback/commit stage with flush-on-commit
// Optional trace ports and retire counter under WB_DEBUG_TRACE_EN.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int RADDR_W    = 5,
  parameter int CSR_ADDR_W = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             mw_valid_i,
  output logic                         wb_allowin_o,
  input  logic [LANES*PC_W-1:0]        mw_pc_i,
  input  logic [LANES-1:0]             mw_regs_we_i,
  input  logic [LANES*RADDR_W-1:0]     mw_regs_waddr_i,
  input  logic [LANES*DATA_W-1:0]      mw_regs_wdata_i,
  input  logic [LANES*EXCEP_W-1:0]     mw_excep_type_i,
  input  logic [LANES-1:0]             mw_is_kernel_i,
  input  logic [LANES*DATA_W-1:0]      mw_mem_addr_i,
  input  logic [CSR_ADDR_W+DATA_W+2:0] mw_csr_i,
  input  logic [1:0]                   cpu_level_i,
  input  logic                         rfb_allowin_i,
  output logic                         wb_to_rfb_valid_o,
  output logic [LANES-1:0]             regs_we_o,
  output logic [LANES*RADDR_W-1:0]     regs_waddr_o,
  output logic [LANES*DATA_W-1:0]      regs_wdata_o,
  output logic                         csr_we_o,
  output logic [CSR_ADDR_W-1:0]        csr_waddr_o,
  output logic [DATA_W-1:0]            csr_wdata_o,
  output logic                         llbit_we_o,
  output logic                         llbit_wdata_o,
  output logic                         excep_en_o,
  output logic                         ertn_en_o,
  output logic [5:0]                   excep_ecode_o,
  output logic [8:0]                   excep_esubcode_o,
  output logic [PC_W-1:0]              excep_pc_o,
  output logic                         excep_badv_we_o,
  output logic [PC_W-1:0]              excep_badv_o,
  output logic                         wb_flush_o
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [LANES*PC_W-1:0]        debug_wb_pc,
  output logic [LANES*4-1:0]           debug_wb_we,
  output logic [LANES*RADDR_W-1:0]     debug_wb_wnum,
  output logic [LANES*DATA_W-1:0]      debug_wb_wdata,
  output logic [63:0]                  retire_cnt
`endif
);

  localparam int CSR_W = 1 + CSR_ADDR_W + DATA_W + 2;

  logic [LANES-1:0]             valid_q;
  logic [LANES*PC_W-1:0]        pc_q;
  logic [LANES-1:0]             regs_we_q;
  logic [LANES*RADDR_W-1:0]     waddr_q;
  logic [LANES*DATA_W-1:0]      wdata_q;
  logic [LANES*EXCEP_W-1:0]     type_q;
  logic [LANES-1:0]             kernel_q;
  logic [LANES*DATA_W-1:0]      addr_q;
  logic [CSR_W-1:0]             csr_q;
  logic [LANES-1:0]             commit;
  logic                         any_valid;
  logic                         accept;

  assign any_valid         = |valid_q;
  assign wb_allowin_o      = !any_valid || rfb_allowin_i;
  assign wb_to_rfb_valid_o = any_valid;
  assign accept            = mw_valid_i[0] && wb_allowin_o && !wb_flush_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      pc_q      <= '0;
      regs_we_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      type_q    <= '0;
      kernel_q  <= '0;
      addr_q    <= '0;
      csr_q     <= '0;
    end else begin
      if (wb_flush_o) begin
        valid_q <= '0;
      end else if (wb_allowin_o) begin
        valid_q <= mw_valid_i[0] ? mw_valid_i : '0;
      end
      if (accept) begin
        pc_q      <= mw_pc_i;
        regs_we_q <= mw_regs_we_i;
        waddr_q   <= mw_regs_waddr_i;
        wdata_q   <= mw_regs_wdata_i;
        type_q    <= mw_excep_type_i;
        kernel_q  <= mw_is_kernel_i;
        addr_q    <= mw_mem_addr_i;
        csr_q     <= mw_csr_i;
      end
    end
  end

  wb_excep_sel #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_excep_sel (
    .valid      (valid_q),
    .excep_type (type_q),
    .is_kernel  (kernel_q),
    .cpu_level  (cpu_level_i),
    .pc         (pc_q),
    .mem_addr   (addr_q),
    .commit     (commit),
    .excep_en   (excep_en_o),
    .ertn_en    (ertn_en_o),
    .ecode      (excep_ecode_o),
    .esubcode   (excep_esubcode_o),
    .excep_pc   (excep_pc_o),
    .badv_we    (excep_badv_we_o),
    .badv       (excep_badv_o)
  );

  assign wb_flush_o   = excep_en_o || ertn_en_o;
  assign regs_we_o    = commit & regs_we_q;
  assign regs_waddr_o = waddr_q;
  assign regs_wdata_o = wdata_q;

  // CSR bundle: {we, addr, wdata, llbit_we, llbit_wdata}, owned by lane 0.
  assign csr_we_o      = commit[0] && csr_q[CSR_W-1];
  assign csr_waddr_o   = csr_q[CSR_W-2 -: CSR_ADDR_W];
  assign csr_wdata_o   = csr_q[DATA_W+1:2];
  assign llbit_we_o    = commit[0] && csr_q[1];
  assign llbit_wdata_o = csr_q[0];

`ifdef WB_DEBUG_TRACE_EN
  logic [63:0] retire_inc;

  assign debug_wb_pc    = pc_q;
  assign debug_wb_wnum  = waddr_q;
  assign debug_wb_wdata = wdata_q;

  always_comb begin
    debug_wb_we = '0;
    retire_inc  = 64'(ertn_en_o);
    for (int k = 0; k < LANES; k++) begin
      debug_wb_we[k*4 +: 4] = {4{commit[k]}};
      retire_inc            = retire_inc + 64'(commit[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (any_valid && rfb_allowin_i) begin
      retire_cnt <= retire_cnt + retire_inc;
    end
  end
`endif

endmodule
